// File: rtl/prefetch_issue_queue_pkg.sv
// Shared types and constants for the prefetch issue queue.
package prefetch_pkg;
  localparam int PF_ADDR_W = 32;
  localparam int CNT_W     = 16;

  typedef logic [PF_ADDR_W-1:0] addr_t;

  typedef enum logic {
    ISSUE_IDLE = 1'b0,
    ISSUE_REQ  = 1'b1
  } issue_state_t;
endpackage

// File: rtl/prefetch_issue_queue_fifo.sv
// Circular-buffer FIFO; push/pop take effect on the clock edge, head is readable combinationally.
// No internal protection: the caller must not push when full or pop when empty.
module prefetch_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// File: rtl/prefetch_issue_queue.sv
// Dedups strobed prefetch addresses, queues survivors and issues them over req/ack; strobe->req is 2 edges.
// No backpressure upstream: misses arriving at a full queue are dropped and counted.
module prefetch_issue_queue
  import prefetch_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int FILTER_ENTRIES = 4,
  parameter int ADDR_W         = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          pf_addr_i,
  input  logic                       pf_strobe_i,
  input  logic                       flush_i,
  output logic                       mem_req_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic                       mem_ack_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic [CNT_W-1:0]           dup_count_o,
  output logic [CNT_W-1:0]           drop_count_o
);
  localparam int FIDX_W = (FILTER_ENTRIES > 1) ? $clog2(FILTER_ENTRIES) : 1;

  logic [ADDR_W-1:0]         filt_addr [FILTER_ENTRIES];
  logic [FILTER_ENTRIES-1:0] filt_vld;
  logic [FIDX_W-1:0]         filt_rr;
  logic                      hit;
  logic                      accept;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic [ADDR_W-1:0]         head_dat;
  issue_state_t              state_q;
  issue_state_t              state_d;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < FILTER_ENTRIES; i++) begin
      if (filt_vld[i] && (filt_addr[i] == pf_addr_i)) hit = 1'b1;
    end
  end

  assign accept = pf_strobe_i && !hit && !fifo_full;

  // The accepted address is written after any same-edge flush, so it survives the flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_vld <= '0;
      filt_rr  <= '0;
      for (int i = 0; i < FILTER_ENTRIES; i++) filt_addr[i] <= '0;
    end else begin
      if (flush_i) filt_vld <= '0;
      if (accept) begin
        filt_addr[filt_rr] <= pf_addr_i;
        filt_vld[filt_rr]  <= 1'b1;
        filt_rr            <= (filt_rr == FIDX_W'(FILTER_ENTRIES - 1)) ? '0 : filt_rr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dup_count_o  <= '0;
      drop_count_o <= '0;
    end else begin
      if (pf_strobe_i && hit && (dup_count_o != '1))
        dup_count_o <= dup_count_o + 1'b1;
      if (pf_strobe_i && !hit && fifo_full && (drop_count_o != '1))
        drop_count_o <= drop_count_o + 1'b1;
    end
  end

  prefetch_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (accept),
    .push_dat (pf_addr_i),
    .pop      (pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (occupancy_o)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ISSUE_IDLE;
      mem_addr_o <= '0;
    end else begin
      state_q <= state_d;
      if (pop) mem_addr_o <= head_dat;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ISSUE_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE_REQ;
        end
      end
      ISSUE_REQ: begin
        if (mem_ack_i) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = ISSUE_IDLE;
        end
      end
      default: state_d = ISSUE_IDLE;
    endcase
  end

  assign mem_req_o = (state_q == ISSUE_REQ);
endmodule
